irq_ctrl: RTL

- Interrupt controller that sits directly upstream of the CSR file.
- Samples external interrupt request lines and masks them with mie from the CSR file.
- Arbitrates among the enabled requests and issues a single trap strobe plus the mcause value; the CSR file latches the PC and cause on that strobe.
- Tracks the in-service interrupt until mret retires, then sends a one-cycle acknowledge to the requesting peripheral.

---
 rtl/irq_pkg.sv | 7 +
 rtl/irq_prio_enc.sv | 21 ++
 rtl/irq_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared state encoding and constants for the interrupt controller
package irq_pkg;
   typedef enum logic [1:0] {IDLE, TRAP, SERVICE, ACK} irq_state_e;
   localparam logic [31:0] MCAUSE_IRQ_BASE = 32'h8000_0010;
   localparam int MIE_IRQ_LSB = 16;
   localparam int ID_W = 4;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: rotating priority encoder, search starts at base_i and wraps
module irq_prio_enc import irq_pkg::*; #(
   parameter int N = 16
) (
   input  logic [N-1:0]    req_i,
   input  logic [ID_W-1:0] base_i,
   output logic            valid_o,
   output logic [ID_W-1:0] id_o
);
   // walk from the farthest offset down so the nearest set bit to base wins
   always_comb begin
      valid_o = 1'b0;
      id_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[(int'(base_i) + i) % N]) begin
            valid_o = 1'b1;
            id_o = ID_W'((int'(base_i) + i) % N);
         end
      end
   end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller feeding the CSR file; IRQ_ROUND_ROBIN_EN selects rotating arbitration
module irq_ctrl import irq_pkg::*; #(
   parameter int IRQ_NUM = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [IRQ_NUM-1:0] irq_req_i,
   input  logic [31:0]        mie_i,
   input  logic               core_ready_i,
   input  logic               mret_i,
   output logic               irq_o,
   output logic [31:0]        mcause_o,
   output logic [IRQ_NUM-1:0] irq_ack_o,
   output logic               busy_o
);
   irq_state_e state_q, state_d;
   logic [ID_W-1:0] id_q, id_d, base, sel_id;
   logic [31:0] mcause_q, mcause_d;
   logic [IRQ_NUM-1:0] req_q, pending, ack;
   logic sel_valid, load, mie_unused;

   assign mie_unused = ^mie_i;
   assign pending = req_q & mie_i[MIE_IRQ_LSB +: IRQ_NUM];
   assign ack = (state_q == ACK) ? IRQ_NUM'(1) << id_q : '0;

`ifdef IRQ_ROUND_ROBIN_EN
   logic [ID_W-1:0] last_q;
   assign base = (int'(last_q) == IRQ_NUM - 1) ? '0 : last_q + ID_W'(1);
   // remember the last serviced line so the next search starts just past it
   always_ff @(posedge clk_i) begin
      if (rst_i) last_q <= ID_W'(IRQ_NUM - 1);
      else if (state_q == ACK) last_q <= id_q;
   end
`else
   assign base = '0;
`endif

   irq_prio_enc #(.N(IRQ_NUM)) u_enc (
      .req_i  (pending),
      .base_i (base),
      .valid_o(sel_valid),
      .id_o   (sel_id)
   );

   // next state, selection latch and cause; only IDLE arbitrates
   always_comb begin
      load = (state_q == IDLE) && sel_valid;
      state_d = (state_q == IDLE)    ? (sel_valid    ? TRAP    : IDLE)    :
                (state_q == TRAP)    ? (core_ready_i ? SERVICE : TRAP)    :
                (state_q == SERVICE) ? (mret_i       ? ACK     : SERVICE) : IDLE;
      id_d = load ? sel_id : id_q;
      mcause_d = load ? MCAUSE_IRQ_BASE + 32'(sel_id) : mcause_q;
   end

   // state registers; the acked line is masked out of the sample so a
   // peripheral dropping its request on the ACK edge cannot retrigger
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         id_q <= '0;
         mcause_q <= '0;
         req_q <= '0;
      end else begin
         state_q <= state_d;
         id_q <= id_d;
         mcause_q <= mcause_d;
         req_q <= irq_req_i & ~ack;
      end
   end

   assign irq_o = (state_q == TRAP);
   assign busy_o = (state_q != IDLE);
   assign mcause_o = mcause_q;
   assign irq_ack_o = ack;
endmodule
